fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the CPU datapath; it replaces the fixed PC register and request-unit instruction path.
- Owns the fetch PC and drives the instruction-memory read handshake (imemREN/ihit).
- Buffers fetched instructions with their PCs in a DEPTH-entry prefetch queue, so decode can consume independently of memory latency.
- Supports redirect (branch/jump) with queue flush, and a sticky halt.

Parameters:
WORD_W, 32, width of PC, address and instruction words
DEPTH, 4, prefetch queue entries; power of two, >= 2
PC_INIT, 0, fetch PC after reset
PC_STEP, 4, PC increment per fetched instruction

Ports:
CLK  in  1  clock, all state updates on rising edge
nRST  in  1  reset; synchronous, active-high (port keeps the codebase name nRST; asserted = 1)
imemREN  out  1  instruction read request
imemaddr  out  WORD_W  address of current request (= fetch_pc)
imemload  in  WORD_W  instruction data, valid when ihit=1
ihit  in  1  memory completes the current request this cycle
redirect  in  1  discard queue and restart fetch at redirect_pc
redirect_pc  in  WORD_W  new fetch target
halt  in  1  stop issuing requests (sticky)
inst_valid  out  1  queue head is valid
inst  out  WORD_W  head instruction
inst_pc  out  WORD_W  PC of head instruction
inst_ready  in  1  consumer pops head this cycle when inst_valid=1
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (nRST=1 at a CLK edge):
  - fetch_pc=PC_INIT; queue empty (rd/wr pointers 0, count=0); halted=0.
  - Outputs after reset: inst_valid=0, inst=0, inst_pc=0, count=0, imemREN=1, imemaddr=PC_INIT.
  - Reset has priority over every other input, including mid-request and mid-redirect.
- Request:
  - imemREN = !halted && (count < DEPTH), combinational. imemaddr = fetch_pc.
  - At most one request is outstanding; address and REN are held stable until ihit.
- Push: ihit && imemREN && !redirect → write {imemload, fetch_pc} at the write pointer; fetch_pc += PC_STEP (mod 2^WORD_W, wraps silently).
- Pop: inst_valid && inst_ready && !redirect → advance the read pointer.
- Pointers wrap modulo DEPTH. A simultaneous push and pop leaves count unchanged.
- Full: with count = DEPTH, imemREN is low that cycle, even if a pop occurs. Fetch resumes the cycle after the pop (one bubble; accepted).
- Empty: inst_valid=0. inst_ready is ignored.
- Head outputs are combinational from the queue head: inst_valid = (count != 0), no added latency. An instruction pushed at edge N is visible at the head after edge N when the queue was empty.
- Redirect (sampled at the edge):
  - Queue flushed (count=0, pointers equal).
  - fetch_pc = {redirect_pc[WORD_W-1:2], 2'b00}.
  - Any ihit or pop in the same cycle is discarded.
  - The next cycle requests the new address (if not halted).
  - Redirect has priority over push, pop and halt-set in the same cycle; halt is still recorded.
- Halt:
  - halted is set at the edge where halt=1 and stays set until reset.
  - While halted: imemREN=0; the queue still drains via inst_ready; redirect still updates fetch_pc and flushes.
  - halt asserted while a request is waiting: REN drops the next cycle. A late ihit is ignored because imemREN=0.
- Invariants: 0 <= count <= DEPTH; no push when full; no pop when empty.

Decomposition:
- cpu_types_pkg gains typedef fetch_entry_t {word_t instr; word_t pc} for the 32-bit build; the parametrised RTL uses a local packed struct of WORD_W fields.
- One sub-module, fetch_fifo: parametrised WIDTH/DEPTH synchronous FIFO with push, pop, flush, count, head data and synchronous active-high reset.
- fetch_unit holds the PC, halt flag and request logic.

Test Plan:
- Reset, defaults: hold nRST=1 for 2 cycles, then release → imemREN=1, imemaddr=0, inst_valid=0, count=0.
- Streaming: ihit=1 every cycle, inst_ready=1, imemload = addr+0x1000 → inst_pc sequence 0,4,8,… with inst=0x1000,0x1004,…; count stays at 1 from the second edge.
- Fill/backpressure (DEPTH=4): inst_ready=0, ihit=1 → count reaches 4, then imemREN=0 with imemaddr=0x10; one pop → count 3, REN=1 the next cycle.
- Wait states: ihit every third cycle → imemaddr held constant between hits, and no duplicate or skipped PCs in the queue.
- Redirect: count=3, redirect=1, redirect_pc=0x40 coinciding with ihit and a pop → next cycle count=0, imemaddr=0x40; the ihit data never appears at the head.
- Halt then reset: halt at fetch_pc=0x20 with 2 entries queued → REN=0, both entries drain, count=0. Assert nRST mid-stream → fetch_pc=0 and halted cleared.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam int DEFAULT_WORD_W  = 32;
  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_PC_STEP = 4;

  // Fixed-width view of a queue entry for the 32-bit build.
  typedef logic [31:0] word_t;
  typedef struct packed {
    word_t instr;
    word_t pc;
  } fetch_entry_t;

  // Width needed to hold an occupancy value in the range 0..depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used as the prefetch queue. The head is read
// combinationally so decode sees a pushed entry right after the push edge.
// Flush empties the queue and overrides any push or pop in the same cycle.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = 2 * DEFAULT_WORD_W,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entry storage; contents need no reset because count guards validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= wr_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding
// imem read at a time, and buffers {instruction, pc} pairs in a prefetch
// queue. Redirect flushes the queue and retargets fetch; halt is sticky
// and only stops new requests, letting queued instructions drain.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              WORD_W  = DEFAULT_WORD_W,
  parameter int              DEPTH   = DEFAULT_DEPTH,
  parameter logic [WORD_W-1:0] PC_INIT = '0,
  parameter int              PC_STEP = DEFAULT_PC_STEP,
  localparam int             CW      = count_width(DEPTH)
) (
  input  logic              CLK,
  input  logic              nRST,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic [WORD_W-1:0] imemload,
  input  logic              ihit,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              inst_valid,
  output logic [WORD_W-1:0] inst,
  output logic [WORD_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic [CW-1:0]     count
);

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } entry_t;

  entry_t            wr_entry, head_entry;
  logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [WORD_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic              halted_reg, halted_next;

  // A full queue blocks requests even if a pop happens this cycle, which
  // keeps REN independent of the consumer at the cost of one bubble.
  assign imemREN    = !halted_reg && !fifo_full;
  assign imemaddr   = fetch_pc_reg;
  assign fifo_push  = ihit && imemREN && !redirect;
  assign inst_valid = !fifo_empty;
  assign fifo_pop   = inst_valid && inst_ready && !redirect;
  assign wr_entry   = entry_t'({imemload, fetch_pc_reg});
  assign inst       = inst_valid ? head_entry.instr : '0;
  assign inst_pc    = inst_valid ? head_entry.pc : '0;

  fetch_fifo #(
    .WIDTH (2 * WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .srst    (nRST),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (redirect),
    .wr_data (wr_entry),
    .rd_data (head_entry),
    .count   (count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Next fetch PC: redirect wins (word-aligned target), else advance on an accepted hit.
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    halted_next   = halted_reg || halt;
    if (redirect) begin
      fetch_pc_next = {redirect_pc[WORD_W-1:2], 2'b00};
    end else if (fifo_push) begin
      fetch_pc_next = fetch_pc_reg + WORD_W'(PC_STEP);
    end
  end

  // PC and halt flag registers; reset overrides everything.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      fetch_pc_reg <= PC_INIT;
      halted_reg   <= 1'b0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      halted_reg   <= halted_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected {inst, pc}
// pairs, a negedge monitor pops and compares every consumed head entry.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  fetch_unit #(
    .WORD_W (32),
    .DEPTH  (4),
    .PC_INIT(32'h0),
    .PC_STEP(4)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .imemload   (imemload),
    .ihit       (ihit),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .count      (count)
  );

  always #5 CLK = ~CLK;

  // Memory model: returns address + 0x1000 as the instruction word.
  assign imemload = imemaddr + 32'h1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_entry(input logic [31:0] pc);
    exp_t e;
    e.inst = pc + 32'h1000;
    e.pc   = pc;
    sb.push_back(e);
  endtask

  // Monitor: every head consumed at the coming edge must match the scoreboard front.
  always @(negedge CLK) begin
    if (!nRST && !redirect && inst_valid && inst_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: got pc %h inst %h, required no entry", inst_pc, inst);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pop_inst", inst, e.inst);
        chk("pop_pc", inst_pc, e.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b1; ihit = 1'b0; redirect = 1'b0; redirect_pc = '0;
    halt = 1'b0; inst_ready = 1'b0;

    // Reset defaults
    cyc(); cyc();
    nRST = 1'b0;
    chk("rst_ren", 32'(imemREN), 32'd1);
    chk("rst_addr", imemaddr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);

    // Streaming: one hit per cycle, consumer always ready
    ihit = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      expect_entry(32'(4 * i));
      cyc();
      chk("stream_count", 32'(count), 32'd1);
    end
    ihit = 1'b0;
    cyc();
    chk("stream_drained", 32'(count), 32'd0);
    chk("stream_addr", imemaddr, 32'h18);
    inst_ready = 1'b0;

    // Fill and backpressure from a fresh reset
    nRST = 1'b1; cyc(); nRST = 1'b0;
    ihit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_entry(32'(4 * i));
      cyc();
      chk("fill_count", 32'(count), 32'(i + 1));
    end
    chk("full_ren", 32'(imemREN), 32'd0);
    chk("full_addr", imemaddr, 32'h10);
    cyc();
    chk("full_hold_count", 32'(count), 32'd4);
    chk("full_hold_addr", imemaddr, 32'h10);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0; ihit = 1'b0;
    chk("after_pop_count", 32'(count), 32'd3);
    chk("after_pop_ren", 32'(imemREN), 32'd1);
    inst_ready = 1'b1;
    cyc(); cyc(); cyc();
    inst_ready = 1'b0;
    chk("fill_drained", 32'(count), 32'd0);

    // Wait states: hit every third cycle, address held between hits
    for (int h = 0; h < 3; h++) begin
      for (int w = 0; w < 2; w++) begin
        chk("wait_addr", imemaddr, 32'h10 + 32'(4 * h));
        cyc();
      end
      chk("wait_addr_hit", imemaddr, 32'h10 + 32'(4 * h));
      expect_entry(32'h10 + 32'(4 * h));
      ihit = 1'b1;
      cyc();
      ihit = 1'b0;
    end
    chk("wait_count", 32'(count), 32'd3);
    inst_ready = 1'b1;
    cyc(); cyc(); cyc();
    inst_ready = 1'b0;
    chk("wait_drained", 32'(count), 32'd0);

    // Redirect with coincident hit and pop; flushed entries are never expected
    ihit = 1'b1;
    cyc(); cyc(); cyc();
    chk("redir_pre_count", 32'(count), 32'd3);
    redirect = 1'b1; redirect_pc = 32'h43; inst_ready = 1'b1;
    cyc();
    redirect = 1'b0; ihit = 1'b0; inst_ready = 1'b0;
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_addr", imemaddr, 32'h40);
    chk("redir_valid", 32'(inst_valid), 32'd0);
    chk("redir_ren", 32'(imemREN), 32'd1);
    expect_entry(32'h40);
    ihit = 1'b1;
    cyc();
    ihit = 1'b0; inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;

    // Halt with two entries queued at fetch_pc 0x20
    redirect = 1'b1; redirect_pc = 32'h18;
    cyc();
    redirect = 1'b0; ihit = 1'b1;
    expect_entry(32'h18);
    cyc();
    expect_entry(32'h1c);
    cyc();
    ihit = 1'b0; halt = 1'b1;
    cyc();
    halt = 1'b0;
    chk("halt_ren", 32'(imemREN), 32'd0);
    chk("halt_addr", imemaddr, 32'h20);
    chk("halt_count", 32'(count), 32'd2);
    ihit = 1'b1; inst_ready = 1'b1;
    cyc(); cyc();
    inst_ready = 1'b0;
    chk("halt_drained", 32'(count), 32'd0);
    chk("halt_ren_sticky", 32'(imemREN), 32'd0);
    ihit = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
    cyc();
    redirect = 1'b0;
    chk("halt_redir_addr", imemaddr, 32'h80);
    chk("halt_redir_ren", 32'(imemREN), 32'd0);
    ihit = 1'b1;
    cyc();
    ihit = 1'b0;
    chk("halt_late_hit", 32'(count), 32'd0);

    // Reset mid-stream, colliding with redirect and hit
    nRST = 1'b1; redirect = 1'b1; redirect_pc = 32'h100; ihit = 1'b1;
    cyc();
    nRST = 1'b0; redirect = 1'b0; ihit = 1'b0;
    chk("rst2_ren", 32'(imemREN), 32'd1);
    chk("rst2_addr", imemaddr, 32'h0);
    chk("rst2_count", 32'(count), 32'd0);

    cyc();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
